tracker_log_buf: RTL and testbench

//  Capture buffer for the per-packet tracker: records {packet_id, timestamp} entries in a
//  2^ADDR_W-deep RAM and serves NoC-side read/meta requests over a valid/ready response stream.

---
 rtl/tracker_log_buf.sv | 171 +++++++++++++++++
 tb/tb_tracker_log_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracker_log_buf.sv
// tracker_log_buf: capture RAM for per-packet tracker entries with a
// request/response front end serving address-range reads and meta queries.
module tracker_log_buf #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 96,
  parameter bit STOP_WHEN_FULL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              log_val,
  input  logic [DATA_W-1:0] log_data,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [1:0]        req_type,
  input  logic [ADDR_W-1:0] req_start,
  input  logic [ADDR_W-1:0] req_end,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [1:0]        resp_type,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] T_READ_REQ  = 2'd0;
  localparam logic [1:0] T_READ_RESP = 2'd1;
  localparam logic [1:0] T_META_REQ  = 2'd2;
  localparam logic [1:0] T_META_RESP = 2'd3;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_STREAM, META} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              resp_val_q, resp_val_d;
  logic [1:0]        resp_type_q, resp_type_d;
  logic              resp_last_q, resp_last_d;
  logic              src_ram_q, src_ram_d;    // beat data comes from the RAM register
  logic [DATA_W-1:0] data_q, data_d;          // meta word, or zero for unwritten slots

  logic              full;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] nxt_ptr;

  // Write-side bookkeeping: pointer advance and saturating occupancy count
  always_comb begin
    full     = (count_q == CNT_MAX);
    wr_en    = log_val && !(STOP_WHEN_FULL && full);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = (wr_en && !full) ? count_q + 1'b1 : count_q;
  end

  // Request FSM; the next beat read is issued only when the current beat is taken
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    end_d       = end_q;
    resp_val_d  = resp_val_q;
    resp_type_d = resp_type_q;
    resp_last_d = resp_last_q;
    src_ram_d   = src_ram_q;
    data_d      = data_q;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q;
    nxt_ptr     = rd_ptr_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (req_val) begin
          if (req_type == T_READ_REQ) begin
            rd_ptr_d = req_start;
            end_d    = req_end;
            state_d  = RD_ISSUE;
          end else if (req_type == T_META_REQ) begin
            resp_val_d  = 1'b1;
            resp_type_d = T_META_RESP;
            resp_last_d = 1'b1;
            src_ram_d   = 1'b0;
            data_d      = DATA_W'({full, count_q});
            state_d     = META;
          end
        end
      end
      RD_ISSUE: begin
        rd_en       = 1'b1;
        rd_addr     = rd_ptr_q;
        resp_val_d  = 1'b1;
        resp_type_d = T_READ_RESP;
        resp_last_d = (rd_ptr_q == end_q);
        src_ram_d   = ({1'b0, rd_ptr_q} < count_q);
        data_d      = '0;
        state_d     = RD_STREAM;
      end
      RD_STREAM: begin
        if (resp_rdy) begin
          if (resp_last_q) begin
            resp_val_d  = 1'b0;
            resp_type_d = 2'd0;
            resp_last_d = 1'b0;
            src_ram_d   = 1'b0;
            state_d     = IDLE;
          end else begin
            rd_en       = 1'b1;
            rd_addr     = nxt_ptr;
            rd_ptr_d    = nxt_ptr;
            resp_last_d = (nxt_ptr == end_q);
            src_ram_d   = ({1'b0, nxt_ptr} < count_q);
          end
        end
      end
      META: begin
        if (resp_rdy) begin
          resp_val_d  = 1'b0;
          resp_type_d = 2'd0;
          resp_last_d = 1'b0;
          data_d      = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      end_q       <= '0;
      resp_val_q  <= 1'b0;
      resp_type_q <= 2'd0;
      resp_last_q <= 1'b0;
      src_ram_q   <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      end_q       <= end_d;
      resp_val_q  <= resp_val_d;
      resp_type_q <= resp_type_d;
      resp_last_q <= resp_last_d;
      src_ram_q   <= src_ram_d;
      data_q      <= data_d;
    end
  end

  // 1R1W storage, read-first on same-address collision, read data held when idle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= log_data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  assign req_rdy   = (state_q == IDLE);
  assign resp_val  = resp_val_q;
  assign resp_type = resp_type_q;
  assign resp_last = resp_last_q;
  assign resp_data = src_ram_q ? ram_q : data_q;

endmodule

// File: tb/tb_tracker_log_buf.sv
// Bench for tracker_log_buf: two instances (stop-when-full and wrapping) share
// all inputs; a queue-based model predicts every response beat.
module tb_tracker_log_buf;
  localparam int AW    = 10;
  localparam int DW    = 96;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          log_val;
  logic [DW-1:0] log_data;
  logic          req_val;
  logic [1:0]    req_type;
  logic [AW-1:0] req_start, req_end;
  logic          resp_rdy;
  logic          rdy0, rdy1, val0, val1, last0, last1;
  logic [1:0]    typ0, typ1;
  logic [DW-1:0] dat0, dat1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tracker_log_buf #(.ADDR_W(AW), .DATA_W(DW), .STOP_WHEN_FULL(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .log_val(log_val), .log_data(log_data),
    .req_val(req_val), .req_rdy(rdy0), .req_type(req_type),
    .req_start(req_start), .req_end(req_end),
    .resp_val(val0), .resp_rdy(resp_rdy), .resp_type(typ0),
    .resp_data(dat0), .resp_last(last0));

  tracker_log_buf #(.ADDR_W(AW), .DATA_W(DW), .STOP_WHEN_FULL(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .log_val(log_val), .log_data(log_data),
    .req_val(req_val), .req_rdy(rdy1), .req_type(req_type),
    .req_start(req_start), .req_end(req_end),
    .resp_val(val1), .resp_rdy(resp_rdy), .resp_type(typ1),
    .resp_data(dat1), .resp_last(last1));

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]    t;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic [DW-1:0] hist[$];   // every entry logged since reset, in order
  beat_t         q0[$], q1[$];
  logic          busy = 1'b0;
  int            pc = 0;
  int            ready_pc = 0;
  logic          ev_m, ev_c;

  // Content of address a as seen by a reader, from the log history alone
  function automatic logic [DW-1:0] stored(input bit stop, input int a);
    int n, cnt, i;
    n   = hist.size();
    cnt = (n > DEPTH) ? DEPTH : n;
    if (a >= cnt) return '0;
    if (stop) return hist[a];
    i = ((n - 1 - a) / DEPTH) * DEPTH + a;
    return hist[i];
  endfunction

  function automatic logic [DW-1:0] meta_word();
    int n, cnt;
    n   = hist.size();
    cnt = (n > DEPTH) ? DEPTH : n;
    return DW'(cnt + ((cnt == DEPTH) ? (2 * DEPTH) : 0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      hist.delete();
      busy     = 1'b0;
      ready_pc = 0;
    end else begin
      ev_m = (q0.size() > 0) && (pc >= ready_pc);
      if (ev_m && resp_rdy) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (q0.size() == 0) busy = 1'b0;
      end else if (req_val && !busy) begin
        if (req_type == 2'd0) begin
          int s, nb;
          beat_t b0, b1;
          s  = int'(req_start);
          nb = ((int'(req_end) - s + DEPTH) % DEPTH) + 1;
          for (int k = 0; k < nb; k++) begin
            int a;
            a = (s + k) % DEPTH;
            b0.t = 2'd1; b0.l = (k == nb - 1); b0.d = stored(1'b1, a);
            b1.t = 2'd1; b1.l = (k == nb - 1); b1.d = stored(1'b0, a);
            q0.push_back(b0);
            q1.push_back(b1);
          end
          ready_pc = pc + 2;
          busy     = 1'b1;
        end else if (req_type == 2'd2) begin
          beat_t bm;
          bm.t = 2'd3; bm.l = 1'b1; bm.d = meta_word();
          q0.push_back(bm);
          q1.push_back(bm);
          ready_pc = pc + 1;
          busy     = 1'b1;
        end
      end
      if (log_val) hist.push_back(log_data);
      pc++;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (rst_n) begin
      ev_c = (q0.size() > 0) && (pc >= ready_pc);
      check("req_rdy_stop", DW'(rdy0), DW'(!busy));
      check("req_rdy_wrap", DW'(rdy1), DW'(!busy));
      check("resp_val_stop", DW'(val0), DW'(ev_c));
      check("resp_val_wrap", DW'(val1), DW'(ev_c));
      if (ev_c) begin
        check("type_stop", DW'(typ0), DW'(q0[0].t));
        check("data_stop", dat0, q0[0].d);
        check("last_stop", DW'(last0), DW'(q0[0].l));
        check("type_wrap", DW'(typ1), DW'(q1[0].t));
        check("data_wrap", dat1, q1[0].d);
        check("last_wrap", DW'(last1), DW'(q1[0].l));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic tog = 1'b0;
  int   hs0 = 0;

  always @(negedge clk) resp_rdy = tog ? ~resp_rdy : 1'b1;
  always @(posedge clk) if (val0 && resp_rdy) hs0++;

  task automatic log_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      log_val  = 1'b1;
      log_data = base + DW'(i);
      @(negedge clk);
    end
    log_val = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] t, input int s, input int e);
    int n = 0;
    while (!rdy0 && n < 3000) begin @(negedge clk); n++; end
    check("req_rdy_wait", DW'(rdy0), DW'(1));
    req_val   = 1'b1;
    req_type  = t;
    req_start = AW'(s);
    req_end   = AW'(e);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic wait_beat(output logic [DW-1:0] d0, output logic [DW-1:0] d1,
                           output logic [1:0] t0, output logic l0);
    int n = 0;
    while (!val0 && n < 50) begin @(negedge clk); n++; end
    check("beat_wait", DW'(val0), DW'(1));
    d0 = dat0; d1 = dat1; t0 = typ0; l0 = last0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && !val0) && n < 3000) begin @(negedge clk); n++; end
    check("idle_wait", DW'(rdy0 && !val0), DW'(1));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, DW'(rdy0), DW'(1));
    check({tag, "_resp_val"}, DW'(val0 | val1), DW'(0));
    check({tag, "_resp_last"}, DW'(last0), DW'(0));
    check({tag, "_resp_type"}, DW'(typ0), DW'(0));
    check({tag, "_resp_data"}, dat0, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d0, d1;
    logic [1:0]    t0;
    logic          l0;
    int            h;

    rst_n = 1'b0; log_val = 1'b0; log_data = '0; req_val = 1'b0;
    req_type = 2'd0; req_start = '0; req_end = '0; resp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Five entries read back-to-back
    log_n(5, 96'hA5A5_0000_0000_0000_0000_0000);
    h = hs0;
    do_req(2'd0, 0, 4);
    wait_beat(d0, d1, t0, l0);
    check("t1_first_data", d0, 96'hA5A5_0000_0000_0000_0000_0000);
    check("t1_first_type", DW'(t0), DW'(1));
    check("t1_first_last", DW'(l0), DW'(0));
    wait_idle();
    check("t1_beats", DW'(hs0 - h), DW'(5));

    // Meta on three entries
    reset_pulse();
    log_n(3, 96'h300);
    do_req(2'd2, 0, 0);
    wait_beat(d0, d1, t0, l0);
    check("t2_meta_data", d0, 96'd3);
    check("t2_meta_type", DW'(t0), DW'(3));
    check("t2_meta_last", DW'(l0), DW'(1));
    wait_idle();

    // Response-type requests are dropped without a response
    h = hs0;
    do_req(2'd1, 0, 0);
    do_req(2'd3, 0, 0);
    repeat (4) @(negedge clk);
    check("drop_no_beat", DW'(hs0 - h), DW'(0));

    // Overfill: stop instance keeps the first entries, wrap keeps the newest
    reset_pulse();
    log_n(1030, 96'h1000);
    do_req(2'd2, 0, 0);
    wait_beat(d0, d1, t0, l0);
    check("t3_meta_stop", d0, 96'hC00);
    check("t3_meta_wrap", d1, 96'hC00);
    wait_idle();
    do_req(2'd0, 0, 5);
    wait_beat(d0, d1, t0, l0);
    check("t3_ram0_stop", d0, 96'h1000);
    check("t3_ram0_wrap", d1, 96'h1400);
    wait_idle();

    // Wrapping address range on a full log
    h = hs0;
    do_req(2'd0, 1022, 1);
    wait_beat(d0, d1, t0, l0);
    check("t4_first_stop", d0, 96'h13FE);
    check("t4_first_wrap", d1, 96'h13FE);
    wait_idle();
    check("t4_beats", DW'(hs0 - h), DW'(4));

    // Stalling consumer over partly unwritten range
    reset_pulse();
    log_n(2, 96'h5000);
    tog = 1'b1;
    h = hs0;
    do_req(2'd0, 0, 3);
    wait_idle();
    tog = 1'b0;
    check("t5_beats", DW'(hs0 - h), DW'(4));
    @(negedge clk);

    // Reset in the middle of a stream
    do_req(2'd0, 0, 9);
    wait_beat(d0, d1, t0, l0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(2'd2, 0, 0);
    wait_beat(d0, d1, t0, l0);
    check("t6_meta_data", d0, '0);
    check("t6_meta_type", DW'(t0), DW'(3));
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
